keypad_scan: RTL



---
 rtl/keypad_scan_if.sv | 30 +++
 rtl/keypad_scan.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/keypad_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan_if
// Brief    : Pin-side bundle of the 4x4 matrix keypad controller.
// Revision : 1.0 - initial release
// ============================================================================
interface keypad_scan_if;
   logic [3:0] row_in;
   logic [3:0] col_out;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_busy;

   modport master (
      input  row_in,
      output col_out,
      output key_code,
      output key_valid,
      output key_busy
   );

   modport slave (
      output row_in,
      input  col_out,
      input  key_code,
      input  key_valid,
      input  key_busy
   );
endinterface
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan
// Brief    : 4x4 keypad column scanner with one shared debounce/dwell timer.
//            Define KEYPAD_REPEAT_EN for auto-repeat strobes while a key is held.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scan #(
   parameter int SCAN_CYCLES     = 50_000,
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_CYCLES   = 25_000_000
) (
   input  logic          clk,
   input  logic          rst,
   keypad_scan_if.master kp
);

   localparam int MAX_A   = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
   localparam int MAX_CYC = (MAX_A > REPEAT_CYCLES) ? MAX_A : REPEAT_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEYPAD_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_PRESS_DB = 2'd1,
      ST_HELD     = 2'd2,
      ST_REL_DB   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       col_q, col_d;
   logic [1:0]       row_l_q, row_l_d;
   logic [3:0]       code_q, code_d;
   logic             valid_q, valid_d;
   logic [3:0]       sync1_q, row_s_q;
   logic [1:0]       low_row;

   // Lowest-index low row wins when several rows are pressed in one column.
   always_comb begin
      low_row = 2'd3;
      if (!row_s_q[0])      low_row = 2'd0;
      else if (!row_s_q[1]) low_row = 2'd1;
      else if (!row_s_q[2]) low_row = 2'd2;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      col_d   = col_q;
      row_l_d = row_l_q;
      code_d  = code_q;
      valid_d = 1'b0;
      case (state_q)
         ST_SCAN: begin
            if (cnt_q == SCAN_LAST) begin
               cnt_d = '0;
               if (row_s_q != 4'hF) begin
                  row_l_d = low_row;
                  state_d = ST_PRESS_DB;
               end else begin
                  col_d = col_q + 2'd1;
               end
            end
         end
         ST_PRESS_DB: begin
            // A bounce back high beats a coincident terminal count.
            if (row_s_q[row_l_q]) begin
               state_d = ST_SCAN;
               cnt_d   = '0;
               col_d   = col_q + 2'd1;
            end else if (cnt_q == DEB_LAST) begin
               state_d = ST_HELD;
               cnt_d   = '0;
               code_d  = {row_l_q, col_q};
               valid_d = 1'b1;
            end
         end
         ST_HELD: begin
            if (row_s_q[row_l_q]) begin
               state_d = ST_REL_DB;
               cnt_d   = '0;
`ifdef KEYPAD_REPEAT_EN
            end else if (cnt_q == REP_LAST) begin
               cnt_d   = '0;
               valid_d = 1'b1;
`else
            end else begin
               cnt_d   = '0;
`endif
            end
         end
         ST_REL_DB: begin
            if (!row_s_q[row_l_q]) begin
               state_d = ST_HELD;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d = ST_SCAN;
               cnt_d   = '0;
               col_d   = 2'd0;
            end
         end
         default: begin
            state_d = ST_SCAN;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_SCAN;
         cnt_q   <= '0;
         col_q   <= 2'd0;
         row_l_q <= 2'd0;
         code_q  <= 4'h0;
         valid_q <= 1'b0;
         sync1_q <= 4'hF;
         row_s_q <= 4'hF;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         col_q   <= col_d;
         row_l_q <= row_l_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         sync1_q <= kp.row_in;
         row_s_q <= sync1_q;
      end
   end

   assign kp.col_out   = ~(4'b0001 << col_q);
   assign kp.key_code  = code_q;
   assign kp.key_valid = valid_q;
   assign kp.key_busy  = (state_q != ST_SCAN);

endmodule
`default_nettype wire
